// File: rtl/uart_byte_fifo.sv
// Byte FIFO between a UART receiver/transmitter and its consumer, with occupancy and almost-full.
// Latency: a byte pushed at edge N is visible at the head right after edge N; one push + one pop per cycle.
// Backpressure: in_ready drops only when full, independent of out_ready; flush discards everything.
module uart_byte_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ALMOST_FULL = 12
) (
    input  logic                  clk,
    input  logic                  reset_low,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AF_CNT    = (DEPTH_LOG2 + 1)'(ALMOST_FULL);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push, pop;

    // Readiness looks only at the stored count, so a full FIFO refuses a push even while popping.
    assign in_ready    = (count_q != DEPTH_CNT);
    assign out_valid   = (count_q != '0);
    assign out_byte    = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_CNT);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; out_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_byte;
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed-vector and scoreboard bench for uart_byte_fifo (DEPTH=16, ALMOST_FULL=12).
module tb_uart_byte_fifo;

    logic       clk = 1'b0;
    logic       reset_low;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [4:0] count;
    logic       almost_full;

    int n_total = 0;
    int n_pass  = 0;

    uart_byte_fifo dut (
        .clk         (clk),
        .reset_low   (reset_low),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] ib;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_ob;
        logic [4:0] e_cnt;
        logic       e_af;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] ib, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_byte   = ib;
        out_ready = ordy;
    endtask

    initial begin
        byte unsigned q[$];

        // Reset held with a byte on offer.
        reset_low = 1'b0;
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_byte", int'(out_byte), 8'h00);
        chk("rst_count", int'(count), 0);
        chk("rst_af", int'(almost_full), 0);
        #8 reset_low = 1'b1;
        step();
        chk("first_push_count", int'(count), 1);
        chk("first_push_byte", int'(out_byte), 8'h11);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        chk("first_pop_count", int'(count), 0);

        // Table: inputs for this cycle, outputs expected before the edge.
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 8'hA1, 5'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB2, 5'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hB2, 5'd1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'hD4, 1'b1, 1'b1, 1'b1, 8'hB2, 5'd2, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'hE5, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hE5, 5'd1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ib, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_byte", i), int'(out_byte), int'(vecs[i].e_ob));
            chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_af", i), int'(almost_full), int'(vecs[i].e_af));
            step();
        end

        // Fill to 16, refuse a 17th, then drain in order.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            #1;
            chk("fill_in_ready", int'(in_ready), 1);
            chk("fill_count", int'(count), i);
            chk("fill_af", int'(almost_full), (i >= 12) ? 1 : 0);
            step();
        end
        chk("full_count", int'(count), 16);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_af", int'(almost_full), 1);
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        step();
        chk("refused_count", int'(count), 16);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_valid", int'(out_valid), 1);
            chk("drain_byte", int'(out_byte), i);
            chk("drain_count", int'(count), 16 - i);
            step();
        end
        chk("drained_valid", int'(out_valid), 0);
        chk("drained_count", int'(count), 0);

        // Full-rate streaming across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
            #1;
            if (i > 0) begin
                chk("stream_count", int'(count), 1);
                chk("stream_byte", int'(out_byte), 8'h80 + i - 1);
            end else begin
                chk("stream_start_count", int'(count), 0);
            end
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        chk("stream_last_byte", int'(out_byte), 8'h80 + 39);
        step();
        chk("stream_end_count", int'(count), 0);

        // Full with simultaneous push and pop: push refused, pop taken.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 8'h55, 1'b1);
        #1;
        chk("fullpop_in_ready", int'(in_ready), 0);
        chk("fullpop_head", int'(out_byte), 8'h20);
        step();
        chk("fullpop_count", int'(count), 15);
        chk("fullpop_newhead", int'(out_byte), 8'h21);
        drive(1'b0, 1'b1, 8'h55, 1'b0);
        #1;
        chk("refill_in_ready", int'(in_ready), 1);
        step();
        chk("refill_count", int'(count), 16);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("fullpop_drain", int'(out_byte), (i < 15) ? (8'h21 + i) : 8'h55);
            step();
        end
        chk("fullpop_empty", int'(out_valid), 0);

        // Flush at count 5 overrides a same-cycle push and pop.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
            step();
        end
        chk("preflush_count", int'(count), 5);
        drive(1'b1, 1'b1, 8'h77, 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("flush_count", int'(count), 0);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_byte", int'(out_byte), 8'h00);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        step();
        chk("postflush_head", int'(out_byte), 8'h3C);
        chk("postflush_count", int'(count), 1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();

        // Random stalls against a queue scoreboard.
        q.delete();
        for (int i = 0; i < 1000; i++) begin
            logic       iv, ordy;
            logic [7:0] b;
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            b    = 8'($urandom_range(0, 255));
            drive(1'b0, iv, b, ordy);
            #1;
            chk("rnd_count", int'(count), q.size());
            chk("rnd_in_ready", int'(in_ready), (q.size() != 16) ? 1 : 0);
            chk("rnd_af", int'(almost_full), (q.size() >= 12) ? 1 : 0);
            if (q.size() != 0) chk("rnd_head", int'(out_byte), int'(q[0]));
            else chk("rnd_empty_byte", int'(out_byte), 0);
            if (int'(count) > 16) chk("rnd_count_bound", int'(count), 16);
            if (ordy && q.size() != 0) void'(q.pop_front());
            else if (ordy && iv && q.size() == 16) void'(q.pop_front());
            if (iv && q.size() < 16 && !(ordy && q.size() == 15 && int'(count) == 16)) q.push_back(b);
            step();
        end

        // Asynchronous reset in mid-operation with data held.
        drive(1'b0, 1'b1, 8'h99, 1'b0);
        step();
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("midrst_before_valid", int'(out_valid), 1);
        reset_low = 1'b0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_byte", int'(out_byte), 8'h00);
        chk("midrst_in_ready", int'(in_ready), 1);
        #3 reset_low = 1'b1;
        step();
        chk("postrst_count", int'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_byte_fifo.md
# uart_byte_fifo

Byte-wide synchronous FIFO placed directly downstream of the UART receiver. It absorbs bursts of received bytes when the consumer stalls, so the receiver's single-byte holding stage does not overrun. It also exposes an occupancy count and an almost-full flag, which drive RTS-style flow control back to the host. The same block may be placed upstream of the UART transmitter with identical behaviour.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: log2 of storage depth. DEPTH = 2^DEPTH_LOG2 = 16 entries. Legal range is 1..8.
- `ALMOST_FULL`, default 12: occupancy threshold for `almost_full`. Legal range is 1..DEPTH.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_low`  input  1: asynchronous, active-low reset.
- `flush`  input  1: synchronous clear; empties the FIFO.
- `in_valid`  input  1: producer presents a byte (connects to the receiver's `rx_valid`).
- `in_ready`  output  1: FIFO accepts a byte this cycle (connects to the receiver's `rx_ready`).
- `in_byte`  input  8: byte to write.
- `out_valid`  output  1: a byte is available at the head.
- `out_ready`  input  1: consumer takes the head byte.
- `out_byte`  output  8: head byte.
- `count`  output  DEPTH_LOG2+1: number of stored bytes, 0..DEPTH.
- `almost_full`  output  1: asserted when `count` >= ALMOST_FULL.

## Operation

- Storage is a DEPTH x 8 array that is not reset. Write pointer `wr_ptr` and read pointer `rd_ptr` are DEPTH_LOG2 bits wide and wrap naturally from DEPTH-1 to 0. `count` is a separate register.
- Push:
  - push = `in_valid` & `in_ready` & !`flush`.
  - On push, `in_byte` is written to `mem[wr_ptr]` and `wr_ptr` increments.
- Pop:
  - pop = `out_valid` & `out_ready` & !`flush`.
  - On pop, `rd_ptr` increments.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `in_ready` = (`count` != DEPTH). It does not depend on `out_ready`, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- `out_valid` = (`count` != 0).
- `out_byte` = `mem[rd_ptr]` when `out_valid`, otherwise 8'h00.
- `almost_full` is a combinational compare on the `count` register.
- `flush`:
  - Sets `wr_ptr`, `rd_ptr` and `count` to 0 on the next edge.
  - Overrides any push or pop in the same cycle; the byte offered that cycle is discarded.
- Data ordering is strictly first-in first-out. No byte is duplicated or lost except through `flush` or reset.

## Timing

- Reset values (asynchronous, immediate on `reset_low`=0): `wr_ptr`=0, `rd_ptr`=0, `count`=0. Consequently:
  - `out_valid`=0
  - `out_byte`=8'h00
  - `in_ready`=1
  - `almost_full`=0, given ALMOST_FULL >= 1
- Write-to-read latency: a byte pushed at edge N appears on `out_byte` with `out_valid`=1 after edge N. The consumer can pop it at edge N+1.
- Throughput: one push and one pop per cycle, sustained indefinitely when 0 < `count` < DEPTH.
- Boundary cases:
  - Empty, push and no pop: `count` goes 0 to 1.
  - Empty: pop is impossible because `out_valid`=0.
  - `count`=1 with push and pop in the same cycle: `count` stays 1 and `out_valid` stays 1. `out_byte` changes to the new byte after the edge.
  - Full (`count`=DEPTH): `in_ready`=0. Push with a simultaneous pop is rejected and `count` becomes DEPTH-1.
  - Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Data integrity across the wrap is required.
- Reset mid-operation clears all state on the same cycle. Stored bytes are lost, and `out_byte` reads 8'h00 until the next push.
- Producer obligation: `in_byte` must be held stable while `in_valid`=1 and `in_ready`=0. The FIFO does not check this.

## Test plan

- Reset with `in_valid`=1: release `reset_low`. Check `in_ready`=1, `out_valid`=0, `out_byte`=8'h00 and `count`=0 during reset. The first push then lands at the next edge.
- Fill and drain: with `out_ready`=0, push 8'h00..8'h0F.
  - `count` reaches 16 and `in_ready` falls after the 16th push.
  - `almost_full` rises when `count`=12.
  - A 17th byte 8'hAA is refused.
  - Set `out_ready`=1: outputs 8'h00..8'h0F in order, then `out_valid`=0.
- Streaming across wrap: push 40 bytes (8'h80+i) at full rate with `out_ready`=1 every cycle. Check `count` stays 1 after the first edge and all 40 bytes come out in order with 1-cycle latency.
- Full with simultaneous pop: at `count`=16, drive `in_valid`=1 (8'h55) and `out_ready`=1. Check the head is popped, 8'h55 is not stored, and `count`=15. Push 8'h55 on the next cycle; it is accepted.
- Flush: at `count`=5, assert `flush` together with `in_valid` and `out_ready`. Next cycle `count`=0 and `out_valid`=0. A subsequent push of 8'h3C emerges as the next head.
- Random stall: run 1000 random `in_valid`/`out_ready` cycles with random data. A scoreboard must match order and `count`, and `count` must never exceed 16.
